// File: rtl/id_ex_ctrl_encoder_if.sv
// id_ex_ctrl_encoder_if: IF/ID-side inputs and ID/EX outputs of the control encoder
interface id_ex_ctrl_encoder_if #(parameter int CNT_W = 16);
  logic [31:0] id_instr;
  logic id_valid, hold, flush;
  logic [1:0] ex_alu_op;
  logic [3:0] ex_funct;
  logic ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_alu_src;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic ex_valid, stall_req, illegal_op;
  logic [CNT_W-1:0] bubble_cnt;
  modport master (
    output id_instr, id_valid, hold, flush,
    input ex_alu_op, ex_funct, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
    input ex_branch, ex_alu_src, ex_rs1, ex_rs2, ex_rd, ex_valid, stall_req, illegal_op, bubble_cnt
  );
  modport slave (
    input id_instr, id_valid, hold, flush,
    output ex_alu_op, ex_funct, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
    output ex_branch, ex_alu_src, ex_rs1, ex_rs2, ex_rd, ex_valid, stall_req, illegal_op, bubble_cnt
  );
endinterface

// File: rtl/id_ex_ctrl_encoder.sv
// id_ex_ctrl_encoder: ID decode, load-use stall, flush/bubble and ID/EX register; ID_EX_ILLEGAL_TRAP_EN enables the illegal-opcode pulse
module id_ex_ctrl_encoder #(parameter int CNT_W = 16) (
  input logic clk,
  input logic reset_n,
  id_ex_ctrl_encoder_if.slave bus
);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_SD = 7'b0100011, OP_BEQ = 7'b1100011;
  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;
  logic is_r, is_i, is_ld, is_sd, is_beq, legal, live, cnt_inc, illegal_next, unused;
  logic [1:0] alu_op;
  logic [3:0] funct;
  assign opcode = bus.id_instr[6:0];
  assign rd = bus.id_instr[11:7];
  assign rs1 = bus.id_instr[19:15];
  assign rs2 = bus.id_instr[24:20];
  assign unused = ^{bus.id_instr[31], bus.id_instr[29:25]};
  assign is_r = opcode == OP_R;
  assign is_i = opcode == OP_I;
  assign is_ld = opcode == OP_LD;
  assign is_sd = opcode == OP_SD;
  assign is_beq = opcode == OP_BEQ;
  assign legal = is_r | is_i | is_ld | is_sd | is_beq;
  assign alu_op = is_r ? 2'b10 : is_beq ? 2'b01 : 2'b00;
  assign funct = {is_r & bus.id_instr[30], bus.id_instr[14:12]};
  // rs2 only matters for opcodes that actually read it; rd=x0 never creates a dependency
  assign bus.stall_req = bus.id_valid & bus.ex_valid & bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                         ((bus.ex_rd == rs1) | ((bus.ex_rd == rs2) & (is_r | is_sd | is_beq)));
  // a dead (bubble, invalid or illegal) instruction carries no controls at all
  assign live = ~bus.flush & ~bus.stall_req & bus.id_valid & legal;
  assign cnt_inc = bus.flush | (~bus.hold & bus.stall_req);
`ifdef ID_EX_ILLEGAL_TRAP_EN
  assign illegal_next = ~bus.flush & ~bus.hold & ~bus.stall_req & bus.id_valid & ~legal;
`else
  assign illegal_next = 1'b0;
`endif
  // ID/EX register: flush beats hold, hold freezes everything, otherwise load (bubble or decode)
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bus.ex_alu_op <= 2'b00;
      bus.ex_funct <= 4'd0;
      bus.ex_reg_write <= 1'b0;
      bus.ex_mem_read <= 1'b0;
      bus.ex_mem_write <= 1'b0;
      bus.ex_mem_to_reg <= 1'b0;
      bus.ex_branch <= 1'b0;
      bus.ex_alu_src <= 1'b0;
      bus.ex_rs1 <= 5'd0;
      bus.ex_rs2 <= 5'd0;
      bus.ex_rd <= 5'd0;
      bus.ex_valid <= 1'b0;
      bus.illegal_op <= 1'b0;
      bus.bubble_cnt <= '0;
    end else begin
      bus.illegal_op <= illegal_next;
      if (cnt_inc && !(&bus.bubble_cnt)) bus.bubble_cnt <= bus.bubble_cnt + 1'b1;
      if (bus.flush || !bus.hold) begin
        bus.ex_valid <= live;
        bus.ex_alu_op <= live ? alu_op : 2'b00;
        bus.ex_reg_write <= live & (is_r | is_i | is_ld);
        bus.ex_mem_read <= live & is_ld;
        bus.ex_mem_write <= live & is_sd;
        bus.ex_mem_to_reg <= live & is_ld;
        bus.ex_branch <= live & is_beq;
        bus.ex_alu_src <= live & (is_i | is_ld | is_sd);
        bus.ex_funct <= funct;
        bus.ex_rs1 <= rs1;
        bus.ex_rs2 <= rs2;
        bus.ex_rd <= rd;
      end
    end
endmodule

// File: tb/tb_id_ex_ctrl_encoder.sv
// tb_id_ex_ctrl_encoder: directed checks of decode, load-use stall, flush/hold, illegal opcodes, reset and saturation
module tb_id_ex_ctrl_encoder;
  logic clk, reset_n;
  int checks = 0, errors = 0;
  id_ex_ctrl_encoder_if #(.CNT_W(16)) b ();
  id_ex_ctrl_encoder_if #(.CNT_W(3)) bs ();
  id_ex_ctrl_encoder #(.CNT_W(16)) dut (.clk(clk), .reset_n(reset_n), .bus(b.slave));
  id_ex_ctrl_encoder #(.CNT_W(3)) dut_s (.clk(clk), .reset_n(reset_n), .bus(bs.slave));
  localparam logic [31:0] ADD = 32'h002081B3, SUB = 32'h402081B3, SLLI = 32'h00109293;
  localparam logic [31:0] SRAI = 32'h4010D293, LD5 = 32'h0000B283, ADD6 = 32'h00228333;
  localparam logic [31:0] SD5 = 32'h0050B023, ADDI7 = 32'h00508393, LD0 = 32'h0000B003;
  localparam logic [31:0] ADD60 = 32'h00200333, BEQ = 32'h00228063, ILL = 32'h0000007F;
`ifdef ID_EX_ILLEGAL_TRAP_EN
  localparam logic ILL_EXP = 1'b1;
`else
  localparam logic ILL_EXP = 1'b0;
`endif
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [31:0] i);
    b.id_instr = i;
    b.id_valid = 1'b1;
  endtask
  initial begin
    reset_n = 1'b0;
    b.id_instr = '0; b.id_valid = 1'b0; b.hold = 1'b0; b.flush = 1'b0;
    bs.id_instr = '0; bs.id_valid = 1'b0; bs.hold = 1'b0; bs.flush = 1'b0;
    repeat (2) step();
    chk("rst_valid", b.ex_valid, 0);
    chk("rst_alu_op", b.ex_alu_op, 0);
    chk("rst_reg_write", b.ex_reg_write, 0);
    chk("rst_cnt", b.bubble_cnt, 0);
    chk("rst_illegal", b.illegal_op, 0);
    reset_n = 1'b1;
    issue(ADD); step();
    chk("add_alu_op", b.ex_alu_op, 2'b10);
    chk("add_funct", b.ex_funct, 4'b0000);
    chk("add_reg_write", b.ex_reg_write, 1);
    chk("add_rd", b.ex_rd, 3);
    chk("add_valid", b.ex_valid, 1);
    issue(SUB); step();
    chk("sub_funct", b.ex_funct, 4'b1000);
    chk("sub_alu_op", b.ex_alu_op, 2'b10);
    issue(SLLI); step();
    chk("slli_funct", b.ex_funct, 4'b0001);
    chk("slli_alu_op", b.ex_alu_op, 2'b00);
    chk("slli_alu_src", b.ex_alu_src, 1);
    issue(SRAI); step();
    chk("srai_funct", b.ex_funct, 4'b0101);
    issue(LD5); step();
    chk("ld_mem_read", b.ex_mem_read, 1);
    chk("ld_mem_to_reg", b.ex_mem_to_reg, 1);
    chk("ld_rd", b.ex_rd, 5);
    issue(ADD6); #1;
    chk("lu_stall", b.stall_req, 1);
    step();
    chk("lu_bubble_valid", b.ex_valid, 0);
    chk("lu_bubble_mem_read", b.ex_mem_read, 0);
    chk("lu_bubble_reg_write", b.ex_reg_write, 0);
    chk("lu_cnt", b.bubble_cnt, 1);
    chk("lu_stall_clear", b.stall_req, 0);
    step();
    chk("lu_add_valid", b.ex_valid, 1);
    chk("lu_add_rd", b.ex_rd, 6);
    chk("lu_add_alu_op", b.ex_alu_op, 2'b10);
    chk("lu_cnt_keep", b.bubble_cnt, 1);
    issue(LD5); step();
    issue(SD5); #1;
    chk("sd_rs2_stall", b.stall_req, 1);
    step();
    chk("sd_bubble_mem_write", b.ex_mem_write, 0);
    chk("sd_cnt", b.bubble_cnt, 2);
    step();
    chk("sd_mem_write", b.ex_mem_write, 1);
    chk("sd_reg_write", b.ex_reg_write, 0);
    chk("sd_alu_src", b.ex_alu_src, 1);
    issue(LD5); step();
    issue(ADDI7); #1;
    chk("i_rs2_nostall", b.stall_req, 0);
    step();
    chk("addi_rd", b.ex_rd, 7);
    chk("addi_reg_write", b.ex_reg_write, 1);
    issue(LD0); step();
    issue(ADD60); #1;
    chk("x0_nostall", b.stall_req, 0);
    issue(LD5); step();
    issue(BEQ); b.flush = 1'b1; #1;
    chk("fl_stall", b.stall_req, 1);
    step();
    chk("fl_valid", b.ex_valid, 0);
    chk("fl_branch", b.ex_branch, 0);
    chk("fl_cnt_once", b.bubble_cnt, 3);
    b.flush = 1'b0; step();
    chk("beq_branch", b.ex_branch, 1);
    chk("beq_alu_op", b.ex_alu_op, 2'b01);
    b.hold = 1'b1; issue(ADD); step(); step();
    chk("hold_alu_op", b.ex_alu_op, 2'b01);
    chk("hold_branch", b.ex_branch, 1);
    chk("hold_rd", b.ex_rd, 0);
    b.hold = 1'b0; issue(LD5); step();
    b.hold = 1'b1; issue(ADD6); step(); step();
    chk("hold_stall_mem_read", b.ex_mem_read, 1);
    chk("hold_stall_cnt", b.bubble_cnt, 3);
    b.hold = 1'b0; step();
    chk("post_hold_cnt", b.bubble_cnt, 4);
    chk("post_hold_valid", b.ex_valid, 0);
    issue(ILL); step();
    chk("ill_valid", b.ex_valid, 0);
    chk("ill_reg_write", b.ex_reg_write, 0);
    chk("ill_pulse", b.illegal_op, ILL_EXP);
    chk("ill_cnt", b.bubble_cnt, 4);
    issue(ADD); step();
    chk("ill_clear", b.illegal_op, 0);
    b.id_valid = 1'b0; step();
    chk("inv_valid", b.ex_valid, 0);
    chk("inv_reg_write", b.ex_reg_write, 0);
    issue(LD5); step();
    issue(ADD6); #1;
    chk("rst_mid_stall_pre", b.stall_req, 1);
    #2 reset_n = 1'b0; #1;
    chk("arst_valid", b.ex_valid, 0);
    chk("arst_mem_read", b.ex_mem_read, 0);
    chk("arst_stall", b.stall_req, 0);
    chk("arst_cnt", b.bubble_cnt, 0);
    #1 reset_n = 1'b1;
    bs.flush = 1'b1;
    repeat (7) step();
    chk("sat_reach", bs.bubble_cnt, 7);
    step();
    chk("sat_hold", bs.bubble_cnt, 7);
    bs.flush = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
